// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer driving a single 1-bit ALU slice over WIDTH cycles.
// Ports: CLK/Reset, Start/OpIn/AIn/BIn request, Alu* slice link, Busy/Done/Result/Cout/Overflow.
module alu_serial_seq #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       OpIn,
    input  logic [WIDTH-1:0] AIn,
    input  logic [WIDTH-1:0] BIn,
    output logic             AluA,
    output logic             AluB,
    output logic             AluCi,
    output logic [2:0]       AluOp,
    output logic             AluLess,
    input  logic             AluR,
    input  logic             AluCo,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Cout,
    output logic             Overflow
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SET,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       op_r;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             sign;

    logic is_slt;
    logic is_addsub;
    logic is_arith;
    logic last;

    assign is_slt    = (op_r == OP_SLT);
    assign is_addsub = (op_r == OP_ADD) || (op_r == OP_SUB);
    assign is_arith  = is_addsub || is_slt;
    assign last      = (idx == LAST);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (Start) state_d = S_RUN;
            S_RUN:  if (last) state_d = is_slt ? S_SET : S_DONE;
            S_SET:  state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Slice drive: SLT runs its subtraction as a plain SUB, then the
    // SET cycle feeds the corrected sign back through the Less input.
    always_comb begin
        AluA    = 1'b0;
        AluB    = 1'b0;
        AluCi   = 1'b0;
        AluOp   = 3'b000;
        AluLess = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        unique case (state_q)
            S_RUN: begin
                AluA  = a_r[idx];
                AluB  = b_r[idx];
                AluCi = carry;
                AluOp = is_slt ? OP_SUB : op_r;
                Busy  = 1'b1;
            end
            S_SET: begin
                AluA    = a_r[0];
                AluB    = b_r[0];
                AluCi   = 1'b1;
                AluOp   = OP_SLT;
                AluLess = sign ^ Overflow;
                Busy    = 1'b1;
            end
            S_DONE: Done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            sign     <= 1'b0;
            Result   <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        a_r      <= AIn;
                        b_r      <= BIn;
                        op_r     <= OpIn;
                        idx      <= '0;
                        carry    <= (OpIn == OP_SUB) || (OpIn == OP_SLT);
                        sign     <= 1'b0;
                        Result   <= '0;
                        Cout     <= 1'b0;
                        Overflow <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (!is_slt) Result[idx] <= AluR;
                    carry <= AluCo;
                    if (!last) begin
                        idx <= idx + 1'b1;
                    end else begin
                        // Signed overflow: carry into MSB differs from carry out.
                        Overflow <= is_arith && (carry ^ AluCo);
                        Cout     <= is_addsub && AluCo;
                        sign     <= AluR;
                    end
                end
                S_SET: begin
                    Result <= {{(WIDTH-1){1'b0}}, AluR};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed testbench for alu_serial_seq with a behavioural 1-bit ALU slice.
// Ports: all DUT ports connected; slice model closes the AluR/AluCo loop.
module tb_alu_serial_seq;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  OpIn;
    logic [15:0] AIn;
    logic [15:0] BIn;
    logic        AluA;
    logic        AluB;
    logic        AluCi;
    logic [2:0]  AluOp;
    logic        AluLess;
    logic        AluR;
    logic        AluCo;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic        Cout;
    logic        Overflow;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    alu_serial_seq #(.WIDTH(16)) dut (
        .CLK(CLK), .Reset(Reset), .Start(Start), .OpIn(OpIn),
        .AIn(AIn), .BIn(BIn), .AluA(AluA), .AluB(AluB),
        .AluCi(AluCi), .AluOp(AluOp), .AluLess(AluLess),
        .AluR(AluR), .AluCo(AluCo), .Busy(Busy), .Done(Done),
        .Result(Result), .Cout(Cout), .Overflow(Overflow)
    );

    // Behavioural ALU1b: Op[0] inverts B, Op[2:1] selects AND/OR/SUM/LESS.
    logic bb;
    always_comb begin
        bb    = AluOp[0] ? ~AluB : AluB;
        AluCo = (AluA & bb) | (AluA & AluCi) | (bb & AluCi);
        case (AluOp[2:1])
            2'b00:   AluR = AluA & bb;
            2'b01:   AluR = AluA | bb;
            2'b10:   AluR = AluA ^ bb ^ AluCi;
            default: AluR = AluLess;
        endcase
    end

    task automatic run_op(input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, output logic [15:0] r,
                          output logic c, output logic v, output int lat);
        logic got;
        got = 1'b0;
        r = 'x; c = 1'bx; v = 1'bx;
        @(negedge CLK);
        Start = 1'b1; OpIn = op; AIn = a; BIn = b;
        @(posedge CLK);
        lat = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge CLK);
            Start = 1'b0;
            if (Done) begin
                r = Result; c = Cout; v = Overflow; got = 1'b1;
            end
            @(posedge CLK);
            lat++;
        end
        if (!got) lat = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; OpIn = '0; AIn = '0; BIn = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        n_chk++;
        if ({Busy, Done, Cout, Overflow} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000", {Busy, Done, Cout, Overflow});
        end
        n_chk++;
        if (Result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_result got %h want 0000", Result);
        end
        n_chk++;
        if ({AluA, AluB, AluCi, AluOp, AluLess} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_alu got %b want 0", {AluA, AluB, AluCi, AluOp, AluLess});
        end
    endtask

    task automatic test_add();
        logic [15:0] r; logic c, v; int lat;
        run_op(3'b100, 16'h7FFF, 16'h0001, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'h8000, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL add_ovf got %h c%b v%b want 8000 c0 v1", r, c, v);
        end
        n_chk++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL add_latency got %0d want 17", lat);
        end
        repeat (3) @(negedge CLK);
        n_chk++;
        if (Result !== 16'h8000) begin
            n_fail++;
            $display("FAIL add_hold got %h want 8000", Result);
        end
    endtask

    task automatic test_sub();
        logic [15:0] r; logic c, v; int lat;
        run_op(3'b101, 16'h0005, 16'h0007, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'hFFFE, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_neg got %h c%b v%b want fffe c0 v0", r, c, v);
        end
        run_op(3'b101, 16'h0007, 16'h0005, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'h0002, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sub_pos got %h c%b v%b want 0002 c1 v0", r, c, v);
        end
    endtask

    task automatic test_slt();
        logic [15:0] r; logic c, v; int lat;
        run_op(3'b111, 16'h8000, 16'h0001, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'h0001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL slt_ovf got %h c%b v%b want 0001 c0 v1", r, c, v);
        end
        n_chk++;
        if (lat !== 18) begin
            n_fail++;
            $display("FAIL slt_latency got %0d want 18", lat);
        end
        run_op(3'b111, 16'h0003, 16'hFFFF, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'h0000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL slt_ge got %h c%b v%b want 0000 c0 v0", r, c, v);
        end
    endtask

    task automatic test_logic();
        logic [15:0] r; logic c, v; int lat;
        run_op(3'b000, 16'hF0F0, 16'h3C3C, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'h3030, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL and got %h c%b v%b want 3030 c0 v0", r, c, v);
        end
        run_op(3'b010, 16'hF0F0, 16'h3C3C, r, c, v, lat);
        n_chk++;
        if ({r, c, v} !== {16'hFCFC, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL or got %h c%b v%b want fcfc c0 v0", r, c, v);
        end
    endtask

    task automatic test_ignore_start();
        logic got;
        got = 1'b0;
        @(negedge CLK);
        Start = 1'b1; OpIn = 3'b100; AIn = 16'h1234; BIn = 16'h1111;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (5) @(negedge CLK);
        n_chk++;
        if ({Busy, AluA, AluB} !== 3'b110) begin
            n_fail++;
            $display("FAIL idx5_drive got %b want 110", {Busy, AluA, AluB});
        end
        Start = 1'b1; OpIn = 3'b000; AIn = 16'hFFFF; BIn = 16'hFFFF;
        @(negedge CLK);
        Start = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            if (Done) begin
                got = 1'b1;
                n_chk++;
                if ({Result, Cout, Overflow} !== {16'h2345, 2'b00}) begin
                    n_fail++;
                    $display("FAIL ignore_start got %h c%b v%b want 2345 c0 v0",
                             Result, Cout, Overflow);
                end
            end
            if (!got) @(negedge CLK);
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL ignore_start_done got timeout want Done");
        end
        @(negedge CLK);
        n_chk++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_no_queue got busy %b want 0", Busy);
        end
    endtask

    task automatic test_back_to_back();
        int t, first, second, pulses;
        t = 0; first = -1; second = -1; pulses = 0;
        @(negedge CLK);
        Start = 1'b1; OpIn = 3'b100; AIn = 16'h0001; BIn = 16'h0002;
        for (int k = 0; k < 60 && pulses < 2; k++) begin
            @(negedge CLK);
            t++;
            if (Done) begin
                if (pulses == 0) first = t;
                else second = t;
                pulses++;
            end
        end
        n_chk++;
        if (pulses !== 2 || (second - first) !== 18) begin
            n_fail++;
            $display("FAIL back_to_back got pulses %0d gap %0d want 2 gap 18",
                     pulses, second - first);
        end
        n_chk++;
        if (Result !== 16'h0003) begin
            n_fail++;
            $display("FAIL back_to_back_result got %h want 0003", Result);
        end
        Start = 1'b0;
        for (int k = 0; k < 30 && (Busy || Done); k++) @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset_midrun();
        logic seen;
        seen = 1'b0;
        @(negedge CLK);
        Start = 1'b1; OpIn = 3'b100; AIn = 16'h00FF; BIn = 16'h0000;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (8) @(negedge CLK);
        n_chk++;
        if ({Busy, Result} !== {1'b1, 16'h00FF}) begin
            n_fail++;
            $display("FAIL midrun_partial got b%b %h want b1 00ff", Busy, Result);
        end
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        n_chk++;
        if ({Busy, Done, Result} !== {2'b00, 16'h0000}) begin
            n_fail++;
            $display("FAIL midrun_reset got b%b d%b %h want b0 d0 0000",
                     Busy, Done, Result);
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge CLK);
            if (Done) seen = 1'b1;
        end
        n_chk++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_no_done got %b want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
